lcd_rgb_capture: RTL and testbench

//  Receive side of the 800x480 parallel RGB565 LCD interface (DEN/HSYNC/VSYNC/RGB).

---
 rtl/lcd_rgb_capture.sv | 277 +++++++++++++++++++++++++++
 tb/tb_lcd_rgb_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_capture.sv
// lcd_rgb_capture: receive side of a parallel RGB565 LCD bus (DEN/HSYNC/VSYNC/RGB).
// Recovers pixel position, measures frame geometry, locks after LOCK_FRAMES
// consecutive matching frames and streams qualified pixels two clocks after sampling.
// Optional feature macro: CAPTURE_CRC_EN (per-frame CRC-16-CCITT over streamed pixels).
module lcd_rgb_capture #(
    parameter int unsigned H_ACTIVE    = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk_pix,
    input  logic        reset,
    input  logic        vid_den,
    input  logic        vid_hsync,
    input  logic        vid_vsync,
    input  logic [4:0]  vid_r,
    input  logic [5:0]  vid_g,
    input  logic [4:0]  vid_b,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] meas_h,
    output logic [15:0] meas_v,
    output logic        err_timing,
    output logic [15:0] frame_crc
);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        den_q, hs_q, vs_q, den_prev_q, hs_prev_q, vs_prev_q;
    logic [15:0] rgb_q;
    state_t      state_q, state_d;
    logic [3:0]  match_q, match_d;
    logic [15:0] h_cnt_q, h_cnt_d, line_q, line_d, maxh_q, maxh_d;
    logic [15:0] meas_h_q, meas_h_d, meas_v_q, meas_v_d;
    logic        bad_q, bad_d;
    logic        p_valid_q, p_sof_q, p_eol_q, p_done_q, p_err_q;
    logic [15:0] p_data_q, p_x_q, p_y_q;
    logic        den_fall_s, vs_fall_s, hs_fall_s, abort_s, line_close_s;
    logic        in_range_s, pix_ok_s, excess_s, line_bad_s, bad_close_s, frame_match_s;
    logic        done_s, err_s;
    logic [15:0] maxh_close_s, lines_close_s, crc_out_s;

    // Input stage: sample the bus once, keep previous sample for edge detection.
    always_ff @(posedge clk_pix or negedge reset) begin
        if (!reset) begin
            den_q      <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            den_prev_q <= 1'b0;
            hs_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            rgb_q      <= 16'd0;
        end else begin
            den_q      <= vid_den;
            hs_q       <= vid_hsync;
            vs_q       <= vid_vsync;
            den_prev_q <= den_q;
            hs_prev_q  <= hs_q;
            vs_prev_q  <= vs_q;
            rgb_q      <= {vid_r, vid_g, vid_b};
        end
    end

    assign den_fall_s   = den_prev_q & ~den_q;
    assign vs_fall_s    = vs_prev_q & ~vs_q;
    assign hs_fall_s    = hs_prev_q & ~hs_q;
    // A frame start with DEN still high aborts the open line.
    assign abort_s      = vs_fall_s & den_q;
    // An aborted line leaves x at 0, so its trailing DEN fall closes nothing.
    assign line_close_s = den_fall_s & (h_cnt_q != 16'd0);
    assign in_range_s   = (h_cnt_q < H_ACT) && (line_q < V_ACT);
    assign pix_ok_s     = den_q && !abort_s && (state_q == ST_LOCKED) && in_range_s;
    assign excess_s     = den_q && !abort_s && !in_range_s;
    assign line_bad_s   = line_close_s && (h_cnt_q != H_ACT);
    assign maxh_close_s = (line_close_s && (h_cnt_q > maxh_q)) ? h_cnt_q : maxh_q;
    assign lines_close_s = line_close_s ? sat_inc(line_q) : line_q;
    assign bad_close_s  = bad_q | excess_s | line_bad_s | abort_s;
    assign frame_match_s = (maxh_close_s == H_ACT) && (lines_close_s == V_ACT) && !bad_close_s;

    // Position counters, frame statistics and lock FSM next-state.
    always_comb begin
        h_cnt_d  = h_cnt_q;
        line_d   = line_q;
        maxh_d   = maxh_close_s;
        bad_d    = bad_close_s;
        state_d  = state_q;
        match_d  = match_q;
        meas_h_d = meas_h_q;
        meas_v_d = meas_v_q;
        done_s   = 1'b0;
        err_s    = 1'b0;
        if (vs_fall_s) begin
            h_cnt_d = 16'd0;
            line_d  = 16'd0;
            maxh_d  = 16'd0;
            bad_d   = 1'b0;
        end else if (den_q) begin
            h_cnt_d = sat_inc(h_cnt_q);
        end else if (den_fall_s || hs_fall_s) begin
            h_cnt_d = 16'd0;
            line_d  = lines_close_s;
        end else begin
            h_cnt_d = h_cnt_q;
        end
        case (state_q)
            ST_SEARCH: begin
                if (vs_fall_s) begin
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                if (vs_fall_s) begin
                    done_s   = 1'b1;
                    meas_h_d = maxh_close_s;
                    meas_v_d = lines_close_s;
                    if (frame_match_s) begin
                        match_d = match_q + 4'd1;
                        if ((match_q + 4'd1) >= LOCK_N) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_MEASURE;
                        end
                    end else begin
                        match_d = 4'd0;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_d = ST_MEASURE;
                end
            end
            ST_LOCKED: begin
                if (vs_fall_s) begin
                    done_s   = 1'b1;
                    meas_h_d = maxh_close_s;
                    meas_v_d = lines_close_s;
                    if (frame_match_s) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_MEASURE;
                        match_d = 4'd0;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                match_d = 4'd0;
            end
        endcase
    end

    // Counter/FSM state plus first output pipeline stage.
    always_ff @(posedge clk_pix or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SEARCH;
            match_q   <= 4'd0;
            h_cnt_q   <= 16'd0;
            line_q    <= 16'd0;
            maxh_q    <= 16'd0;
            bad_q     <= 1'b0;
            meas_h_q  <= 16'd0;
            meas_v_q  <= 16'd0;
            p_valid_q <= 1'b0;
            p_data_q  <= 16'd0;
            p_x_q     <= 16'd0;
            p_y_q     <= 16'd0;
            p_sof_q   <= 1'b0;
            p_eol_q   <= 1'b0;
            p_done_q  <= 1'b0;
            p_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            h_cnt_q   <= h_cnt_d;
            line_q    <= line_d;
            maxh_q    <= maxh_d;
            bad_q     <= bad_d;
            meas_h_q  <= meas_h_d;
            meas_v_q  <= meas_v_d;
            p_valid_q <= pix_ok_s;
            p_data_q  <= pix_ok_s ? rgb_q : 16'd0;
            p_x_q     <= pix_ok_s ? h_cnt_q : 16'd0;
            p_y_q     <= pix_ok_s ? line_q : 16'd0;
            p_sof_q   <= pix_ok_s && (h_cnt_q == 16'd0) && (line_q == 16'd0);
            p_eol_q   <= pix_ok_s && (h_cnt_q == (H_ACT - 16'd1));
            p_done_q  <= done_s;
            p_err_q   <= err_s;
        end
    end

`ifdef CAPTURE_CRC_EN
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [15:0] crc_run_q, crc_frame_q;

    // Running CRC over streamed pixels; snapshot and re-init at each frame start.
    always_ff @(posedge clk_pix or negedge reset) begin
        if (!reset) begin
            crc_run_q   <= 16'hFFFF;
            crc_frame_q <= 16'h0000;
        end else if (vs_fall_s) begin
            crc_run_q   <= 16'hFFFF;
            crc_frame_q <= done_s ? crc_run_q : crc_frame_q;
        end else if (pix_ok_s) begin
            crc_run_q   <= crc16_step(crc_run_q, rgb_q);
        end else begin
            crc_run_q   <= crc_run_q;
        end
    end

    assign crc_out_s = crc_frame_q;
`else
    assign crc_out_s = 16'h0000;
`endif

    // Output registers: second pipeline stage, cleared at once by reset.
    always_ff @(posedge clk_pix or negedge reset) begin
        if (!reset) begin
            pix_valid  <= 1'b0;
            pix_data   <= 16'd0;
            pix_x      <= 16'd0;
            pix_y      <= 16'd0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            meas_h     <= 16'd0;
            meas_v     <= 16'd0;
            err_timing <= 1'b0;
            frame_crc  <= 16'd0;
        end else begin
            pix_valid  <= p_valid_q;
            pix_data   <= p_data_q;
            pix_x      <= p_x_q;
            pix_y      <= p_y_q;
            pix_sof    <= p_sof_q;
            pix_eol    <= p_eol_q;
            locked     <= (state_q == ST_LOCKED);
            frame_done <= p_done_q;
            meas_h     <= meas_h_q;
            meas_v     <= meas_v_q;
            err_timing <= p_err_q;
            frame_crc  <= crc_out_s;
        end
    end
endmodule

// File: tb/tb_lcd_rgb_capture.sv
// Self-checking bench for lcd_rgb_capture on a scaled 8x4 geometry.
// Honours CAPTURE_CRC_EN the same way as the design.
module tb_lcd_rgb_capture;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int LF = 2;

    logic        clk_pix, reset, vid_den, vid_hsync, vid_vsync;
    logic [4:0]  vid_r, vid_b;
    logic [5:0]  vid_g;
    logic        pix_valid, pix_sof, pix_eol, locked, frame_done, err_timing;
    logic [15:0] pix_data, pix_x, pix_y, meas_h, meas_v, frame_crc;

    lcd_rgb_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LF)) dut (
        .clk_pix(clk_pix), .reset(reset), .vid_den(vid_den), .vid_hsync(vid_hsync),
        .vid_vsync(vid_vsync), .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .locked(locked), .frame_done(frame_done),
        .meas_h(meas_h), .meas_v(meas_v), .err_timing(err_timing), .frame_crc(frame_crc)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    int cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    typedef struct {
        int          s;
        logic [15:0] d, x, y;
        logic        sof, eol;
    } pix_t;
    pix_t q[$];

    int n_pass = 0, n_total = 0;
    int mstate = 0, mcnt = 0, frame_no = 0;
    bit mlocked = 1'b0;
    int fr_lines = 0, fr_maxh = 0;
    bit fr_good = 1'b1;
    logic [15:0] exp_mh = 16'd0, exp_mv = 16'd0, exp_crc = 16'd0, crc_acc = 16'hFFFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] gold_crc(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = (r << 1) ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Scoreboard: each expected pixel must appear exactly two clocks after its sample.
    always @(negedge clk_pix) begin
        pix_t e;
        bit   exp_v;
        if (reset) begin
            exp_v = (q.size() > 0) && (q[0].s + 2 == cyc);
            if (pix_valid || exp_v) begin
                chk("pix_valid", 32'(pix_valid), 32'(exp_v));
                if (exp_v) begin
                    e = q.pop_front();
                    if (pix_valid) begin
                        chk("pix_data", 32'(pix_data), 32'(e.d));
                        chk("pix_xy", {pix_x, pix_y}, {e.x, e.y});
                        chk("pix_flags", 32'({pix_sof, pix_eol}), 32'({e.sof, e.eol}));
                    end
                end
            end
        end
    end

    task automatic drv(input bit den, input bit hs, input bit vs, input logic [15:0] d);
        @(negedge clk_pix);
        vid_den   = den;
        vid_hsync = hs;
        vid_vsync = vs;
        {vid_r, vid_g, vid_b} = d;
    endtask

    task automatic vsync_pulse(input bit den_hi);
        bit done, bad;
        drv(den_hi, 1'b1, 1'b0, 16'h0000);
        done = (mstate != 0);
        bad  = !(fr_good && !den_hi && fr_lines == V && fr_maxh == H);
        if (done) begin
            exp_mh = 16'(fr_maxh);
            exp_mv = 16'(fr_lines);
`ifdef CAPTURE_CRC_EN
            exp_crc = crc_acc;
`endif
        end
        if (mstate == 0) begin
            mstate = 1;
        end else if (mstate == 1) begin
            if (bad) mcnt = 0;
            else begin
                mcnt++;
                if (mcnt >= LF) mstate = 2;
            end
        end else if (bad) begin
            mstate = 1;
            mcnt   = 0;
        end
        mlocked  = (mstate == 2);
        fr_lines = 0;
        fr_maxh  = 0;
        fr_good  = 1'b1;
        crc_acc  = 16'hFFFF;
        drv(1'b0, 1'b1, 1'b0, 16'h0000);
        drv(1'b0, 1'b1, 1'b1, 16'h0000);
        @(negedge clk_pix);
        chk("frame_done", 32'(frame_done), 32'(done));
        chk("err_timing", 32'(err_timing), 32'(done && bad));
        chk("locked", 32'(locked), 32'(mlocked));
        chk("meas_h", 32'(meas_h), 32'(exp_mh));
        chk("meas_v", 32'(meas_v), 32'(exp_mv));
        chk("frame_crc", 32'(frame_crc), 32'(exp_crc));
    endtask

    task automatic reset_mid();
        @(negedge clk_pix);
        reset   = 1'b0;
        vid_den = 1'b0;
        #1;
        chk("rst_flags", 32'({pix_valid, pix_sof, pix_eol, locked, frame_done, err_timing}), 32'd0);
        chk("rst_data_x", {pix_data, pix_x}, 32'd0);
        chk("rst_y_mh", {pix_y, meas_h}, 32'd0);
        chk("rst_mv_crc", {meas_v, frame_crc}, 32'd0);
        q.delete();
        mstate = 0; mcnt = 0; mlocked = 1'b0;
        fr_lines = 0; fr_maxh = 0; fr_good = 1'b1; crc_acc = 16'hFFFF;
        exp_mh = 16'd0; exp_mv = 16'd0; exp_crc = 16'd0;
        repeat (3) @(negedge clk_pix);
        reset = 1'b1;
    endtask

    task automatic drive_frame(input int bad_line, input int bad_len, input int abort_line,
                               input int abort_x, input bit ff, input int fp,
                               input int rst_line, output bit ended);
        int          len;
        logic [15:0] d;
        pix_t        e;
        ended = 1'b0;
        frame_no++;
        drv(1'b0, 1'b1, 1'b1, 16'h0000);
        drv(1'b0, 1'b1, 1'b1, 16'h0000);
        for (int l = 0; l < V; l++) begin
            drv(1'b0, 1'b0, 1'b1, 16'h0000);
            drv(1'b0, 1'b1, 1'b1, 16'h0000);
            len = (l == bad_line) ? bad_len : H;
            for (int x = 0; x < len; x++) begin
                if (l == abort_line && x == abort_x) begin
                    vsync_pulse(1'b1);
                    ended = 1'b1;
                    return;
                end
                if (l == rst_line && x == H / 2) begin
                    reset_mid();
                    ended = 1'b1;
                    return;
                end
                d = ff ? 16'hFFFF : 16'(l * 256 + x * 3 + frame_no * 17);
                drv(1'b1, 1'b1, 1'b1, d);
                if (mlocked && x < H) begin
                    e.s = cyc + 1; e.d = d; e.x = 16'(x); e.y = 16'(l);
                    e.sof = (x == 0 && l == 0);
                    e.eol = (x == H - 1);
                    q.push_back(e);
                    crc_acc = gold_crc(crc_acc, d);
                end
            end
            if (len > fr_maxh) fr_maxh = len;
            if (len != H) fr_good = 1'b0;
            fr_lines++;
            if (l < V - 1 || fp > 0) drv(1'b0, 1'b1, 1'b1, 16'h0000);
        end
        for (int i = 1; i < fp; i++) drv(1'b0, 1'b1, 1'b1, 16'h0000);
    endtask

    task automatic good_frame();
        bit ended;
        drive_frame(-1, 0, -1, 0, 1'b0, 2, -1, ended);
        vsync_pulse(1'b0);
    endtask

    initial begin
        bit ended;
        reset = 1'b0; vid_den = 1'b0; vid_hsync = 1'b1; vid_vsync = 1'b1;
        vid_r = 5'd0; vid_g = 6'd0; vid_b = 5'd0;
        repeat (3) @(negedge clk_pix);
        chk("reset_flags", 32'({pix_valid, pix_sof, pix_eol, locked, frame_done, err_timing}), 32'd0);
        chk("reset_meas", {meas_h, meas_v}, 32'd0);
        reset = 1'b1;
        repeat (3) drv(1'b0, 1'b1, 1'b1, 16'h0000);
        // Lock-up: first vsync only opens measurement, lock at the third.
        vsync_pulse(1'b0);
        good_frame();
        drive_frame(-1, 0, -1, 0, 1'b0, 0, -1, ended);   // closing DEN fall coincides with vsync fall
        vsync_pulse(1'b0);
        good_frame();
        // Short line while locked.
        drive_frame(2, H - 1, -1, 0, 1'b0, 2, -1, ended);
        vsync_pulse(1'b0);
        good_frame();
        good_frame();
        good_frame();
        // Overlong line while locked: excess pixels dropped.
        drive_frame(1, H + 5, -1, 0, 1'b0, 2, -1, ended);
        vsync_pulse(1'b0);
        good_frame();
        good_frame();
        // Frame start mid-line.
        drive_frame(-1, 0, 2, 4, 1'b0, 2, -1, ended);
        good_frame();
        good_frame();
        // Constant 16'hFFFF frame for the CRC snapshot.
        drive_frame(-1, 0, -1, 0, 1'b1, 2, -1, ended);
        vsync_pulse(1'b0);
        // Reset in the middle of a streamed frame, then relock.
        drive_frame(-1, 0, -1, 0, 1'b0, 2, 2, ended);
        repeat (3) drv(1'b0, 1'b1, 1'b1, 16'h0000);
        vsync_pulse(1'b0);
        good_frame();
        good_frame();
        good_frame();
        repeat (4) drv(1'b0, 1'b1, 1'b1, 16'h0000);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
